pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/interlock controller for the 5-stage pipeline. Sits beside the ID/EXE and EXE/MEM pipeline registers.
//  Generates the ID-stage operand-forwarding selects and the load-use stall. Sequences the multi-cycle mul/div
//  unit (MDU) and stalls HI/LO consumers until the MDU finishes. Drives PC/IF-ID write enable, ID/EXE bubble, stall counter.
// PARAMETERS
//  MDU_LAT   32  MDU execution cycles after start; legal range 2..255
//  CNT_W     32  width of saturating stall-cycle counter
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      reset: synchronous, active-high
//  rs, rt     in   5      source register numbers of the instruction in ID
//  use_rs     in   1      ID instruction reads rs
//  use_rt     in   1      ID instruction reads rt
//  dmdu       in   1      ID instruction is mult/multu/div/divu
//  dhilo      in   1      ID instruction reads HI/LO (mfhi/mflo)
//  ewreg,em2reg in 1      write-reg / load flags of the instruction in EXE
//  ern        in   5      destination register of the instruction in EXE
//  mwreg,mm2reg in 1      write-reg / load flags of the instruction in MEM
//  mrn        in   5      destination register of the instruction in MEM
//  fwda, fwdb out  2      operand select: 00 regfile, 01 EXE alu, 10 MEM alu, 11 MEM load data
//  wpcir      out  1      1 = PC and IF/ID write enabled; 0 = hold (stall)
//  bubble     out  1      1 = force dwreg/dm2reg/dwmem/djal to 0 into ID/EXE this cycle
//  mdu_start  out  1      one-cycle start pulse to the MDU
//  mdu_busy   out  1      MDU executing
//  stall_cnt  out  CNT_W  cycles with wpcir==0 since reset, saturates at all-ones
// BEHAVIOUR
//  Reset: state IDLE, count 0, stall_cnt 0, mdu_busy 0. Combinational outputs follow inputs with the IDLE state, i.e. during reset
//   fwda/fwdb per rules below, mdu_start 0 (gated by rst), wpcir/bubble from load-use only.
//  Forwarding (combinational, per operand x in {rs,rt}, register 0 never forwarded):
//   ewreg & ~em2reg & ern!=0 & ern==x -> 01; else mwreg & mrn!=0 & mrn==x -> (mm2reg ? 11 : 10); else 00.
//   EXE match has priority over MEM match. Select is computed even if use_x==0.
//  Load-use stall: lu = ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)). Exactly 1 cycle.
//  MDU FSM (states IDLE, BUSY; counter cnt, 8 bit):
//   IDLE: dmdu & ~lu -> mdu_start=1, next BUSY, cnt<=MDU_LAT.
//   BUSY: cnt<=cnt-1 each cycle; cnt==1 -> next IDLE. mdu_busy=1 in BUSY. Busy for exactly MDU_LAT cycles.
//   md_stall = BUSY & (dhilo | dmdu). Back-to-back mdu op waits in ID and issues the first IDLE cycle.
//   mdu_start never asserted in BUSY or while lu or rst.
//  stall = lu | md_stall; wpcir = ~stall; bubble = stall. Simultaneous lu and md_stall: single combined stall, stall_cnt +1.
//  stall_cnt: +1 per cycle with stall==1 and rst==0; holds at 2^CNT_W-1.
//  Reset mid-BUSY: next cycle IDLE, cnt 0, mdu_busy 0; the in-flight MDU result is discarded (MDU reset by same rst).
//  Branch delay slot architecture: no flush output; stall does not interact with branch resolution.
// STRUCTURE
//  Package pipe_ctrl_pkg: fwd_sel_t enum {FWD_RF=2'b00, FWD_EXE=2'b01, FWD_MALU=2'b10, FWD_MMEM=2'b11},
//   mdu_state_t enum {MDU_IDLE, MDU_BUSY}, REG_ZERO=5'd0.
//  Sub-module mdu_timer: FSM + down-counter (start, busy, done_next); top holds forwarding, stall logic, stall_cnt.
// TESTING
//  1. ewreg=1,em2reg=0,ern=5,rs=5,use_rs=1 -> fwda=01, wpcir=1, bubble=0.
//  2. mwreg=1,mm2reg=1,mrn=7,rt=7, no EXE match -> fwdb=11; add ewreg=1,ern=7 -> fwdb=01.
//  3. Load in EXE (em2reg=1,ern=8), ID rt=8,use_rt=1 -> wpcir=0,bubble=1 one cycle; stall_cnt 0->1; ern=0 case -> no stall.
//  4. dmdu=1 at T (MDU_LAT=4) -> mdu_start at T, mdu_busy T+1..T+4; dhilo=1 from T+1 -> wpcir=0 T+1..T+4, 1 at T+5; stall_cnt=4.
//  5. Second dmdu at T+1 -> stalled until T+5, mdu_start pulses at T+5 exactly once.
//  6. rst=1 at T+2 of BUSY -> T+3 mdu_busy=0, stall_cnt=0, no mdu_start; stall_cnt forced to 2^CNT_W-2, 3 stalls -> saturates all-ones.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and the operand-forwarding select function for the pipeline
// hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_EXE  = 2'b01,
    FWD_MALU = 2'b10,
    FWD_MMEM = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load still in EXE has no data yet, so it is never an EXE forward source.
  function automatic fwd_sel_t fwd_sel(input logic [4:0] x,
                                       input logic       ewreg,
                                       input logic       em2reg,
                                       input logic [4:0] ern,
                                       input logic       mwreg,
                                       input logic       mm2reg,
                                       input logic [4:0] mrn);
    if (ewreg && !em2reg && ern != REG_ZERO && ern == x) return FWD_EXE;
    if (mwreg && mrn != REG_ZERO && mrn == x) return mm2reg ? FWD_MMEM : FWD_MALU;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_timer.sv
// Tracks the multi-cycle mul/div unit: issues the start pulse and stays busy
// for exactly MDU_LAT cycles afterwards.
module mdu_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic start,
  output logic busy
);

  mdu_state_t state;
  logic [7:0] cnt;
  logic       done_next;

  assign done_next = (state == MDU_BUSY) && (cnt == 8'd1);
  assign start     = (state == MDU_IDLE) && go && !rst;
  assign busy      = (state == MDU_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MDU_IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        MDU_IDLE: if (go) begin
          state <= MDU_BUSY;
          cnt   <= 8'(MDU_LAT);
        end
        MDU_BUSY: begin
          cnt <= cnt - 8'd1;
          if (done_next) state <= MDU_IDLE;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/interlock controller: ID-stage forwarding selects, load-use and
// HI/LO-busy stalls, MDU sequencing and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             dmdu,
  input  logic             dhilo,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic lu, md_stall, stall;

  assign fwda = fwd_sel(rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
  assign fwdb = fwd_sel(rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);

  assign lu = ewreg && em2reg && (ern != REG_ZERO) &&
              ((use_rs && ern == rs) || (use_rt && ern == rt));

  // A new MDU op must not issue while it is itself waiting on a load.
  mdu_timer #(.MDU_LAT(MDU_LAT)) u_mdu_timer (
    .clk   (clk),
    .rst   (rst),
    .go    (dmdu && !lu),
    .start (mdu_start),
    .busy  (mdu_busy)
  );

  // The MDU is cleared by the same reset, so a busy unit never stalls in reset.
  assign md_stall = mdu_busy && !rst && (dhilo || dmdu);
  assign stall    = lu || md_stall;
  assign wpcir    = !stall;
  assign bubble   = stall;

  always_ff @(posedge clk) begin
    if (rst)                      stall_cnt <= '0;
    else if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs, rt, ern, mrn;
  logic use_rs, use_rt, dmdu, dhilo, ewreg, em2reg, mwreg, mm2reg;
  logic [1:0] fwda, fwdb;
  logic wpcir, bubble, mdu_start, mdu_busy;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int passes = 0;

  // reference model state: MDU cycles remaining, stall count
  int m_left = 0;
  int m_cnt  = 0;
  logic [1:0] m_fwda, m_fwdb;
  logic m_lu, m_stall, m_start, m_busy;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .dmdu(dmdu), .dhilo(dhilo), .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
    .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .fwda(fwda), .fwdb(fwdb),
    .wpcir(wpcir), .bubble(bubble), .mdu_start(mdu_start), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt)
  );

  function automatic logic [1:0] ref_fwd(input logic [4:0] x);
    if (ewreg && !em2reg && ern != 0 && ern == x) return 2'd1;
    if (mwreg && mrn != 0 && mrn == x) return mm2reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic void model_eval();
    m_fwda  = ref_fwd(rs);
    m_fwdb  = ref_fwd(rt);
    m_lu    = ewreg && em2reg && ern != 0 &&
              ((use_rs && ern == rs) || (use_rt && ern == rt));
    m_busy  = (m_left > 0);
    m_stall = m_lu || (!rst && m_busy && (dhilo || dmdu));
    m_start = !rst && !m_busy && dmdu && !m_lu;
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      m_left = 0;
      m_cnt  = 0;
    end else begin
      if (m_start) m_left = LAT;
      else if (m_left > 0) m_left = m_left - 1;
      if (m_stall && m_cnt < CMAX) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rs = 0; rt = 0; ern = 0; mrn = 0;
    use_rs = 0; use_rt = 0; dmdu = 0; dhilo = 0;
    ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_inputs();
    tick(); tick();
    rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    tick(); tick();
    dmdu = 1'b1; #1;
    checks++;
    if ({mdu_start, mdu_busy, stall_cnt} !== {1'b0, 1'b0, 4'd0}) $display("FAIL reset_state start=%b busy=%b cnt=%0d exp 0/0/0", mdu_start, mdu_busy, stall_cnt);
    else passes++;
    dmdu = 1'b0; ewreg = 1; em2reg = 1; ern = 5'd3; rs = 5'd3; use_rs = 1; #1;
    checks++;
    if ({wpcir, bubble} !== 2'b01) $display("FAIL reset_lu wpcir/bubble=%b exp 01", {wpcir, bubble});
    else passes++;
    tick();
    checks++;
    if (stall_cnt !== 4'd0) $display("FAIL reset_cnt_hold got %0d exp 0", stall_cnt);
    else passes++;
    rst = 1'b0; idle_inputs(); #1;
  endtask

  task automatic test_forwarding();
    idle_inputs();
    ewreg = 1; em2reg = 0; ern = 5'd5; rs = 5'd5; use_rs = 1; #1;
    checks++;
    if ({fwda, wpcir, bubble} !== 4'b0110) $display("FAIL fwd_exe fwda/wpcir/bubble=%b exp 0110", {fwda, wpcir, bubble});
    else passes++;
    idle_inputs();
    mwreg = 1; mm2reg = 1; mrn = 5'd7; rt = 5'd7; #1;
    checks++;
    if (fwdb !== 2'b11) $display("FAIL fwd_mmem fwdb=%b exp 11", fwdb);
    else passes++;
    ewreg = 1; ern = 5'd7; #1;
    checks++;
    if (fwdb !== 2'b01) $display("FAIL fwd_exe_prio fwdb=%b exp 01", fwdb);
    else passes++;
    mm2reg = 0; ewreg = 0; #1;
    checks++;
    if (fwdb !== 2'b10) $display("FAIL fwd_malu fwdb=%b exp 10", fwdb);
    else passes++;
    idle_inputs();
    ewreg = 1; mwreg = 1; ern = 0; mrn = 0; rs = 0; rt = 0; #1;
    checks++;
    if ({fwda, fwdb} !== 4'b0000) $display("FAIL fwd_r0 fwda/fwdb=%b exp 0000", {fwda, fwdb});
    else passes++;
    idle_inputs(); #1;
  endtask

  task automatic test_load_use();
    do_reset();
    ewreg = 1; em2reg = 1; ern = 5'd8; rt = 5'd8; use_rt = 1; #1;
    checks++;
    if ({wpcir, bubble} !== 2'b01) $display("FAIL lu_stall wpcir/bubble=%b exp 01", {wpcir, bubble});
    else passes++;
    tick();
    idle_inputs(); rt = 5'd8; use_rt = 1; mwreg = 1; mm2reg = 1; mrn = 5'd8; #1;
    checks++;
    if ({wpcir, bubble, fwdb, stall_cnt} !== {2'b10, 2'b11, 4'd1}) $display("FAIL lu_release wpcir/bubble/fwdb/cnt=%b exp 1011_0001", {wpcir, bubble, fwdb, stall_cnt});
    else passes++;
    idle_inputs(); ewreg = 1; em2reg = 1; ern = 0; rt = 0; use_rt = 1; #1;
    checks++;
    if (wpcir !== 1'b1) $display("FAIL lu_r0 wpcir=%b exp 1", wpcir);
    else passes++;
    ern = 5'd9; rt = 5'd9; use_rt = 0; #1;
    checks++;
    if (wpcir !== 1'b1) $display("FAIL lu_unused wpcir=%b exp 1", wpcir);
    else passes++;
    idle_inputs(); #1;
  endtask

  task automatic test_mdu_hilo();
    do_reset();
    dmdu = 1; #1;
    checks++;
    if ({mdu_start, mdu_busy, wpcir} !== 3'b101) $display("FAIL mdu_issue start/busy/wpcir=%b exp 101", {mdu_start, mdu_busy, wpcir});
    else passes++;
    tick();
    dmdu = 0; dhilo = 1;
    for (int i = 1; i <= LAT; i++) begin
      #1;
      checks++;
      if ({mdu_start, mdu_busy, wpcir} !== 3'b010) $display("FAIL mdu_busy_T%0d start/busy/wpcir=%b exp 010", i, {mdu_start, mdu_busy, wpcir});
      else passes++;
      tick();
    end
    checks++;
    if ({mdu_busy, wpcir, stall_cnt} !== {2'b01, 4'd4}) $display("FAIL mdu_done busy/wpcir/cnt=%b exp 01_0100", {mdu_busy, wpcir, stall_cnt});
    else passes++;
    idle_inputs(); #1;
  endtask

  task automatic test_back_to_back();
    int starts;
    do_reset();
    dmdu = 1;
    starts = 0;
    for (int i = 0; i <= LAT; i++) begin
      #1;
      if (mdu_start) starts++;
      if (i >= 1) begin
        checks++;
        if (wpcir !== 1'b0) $display("FAIL b2b_wait_T%0d wpcir=%b exp 0", i, wpcir);
        else passes++;
      end
      tick();
    end
    #1;
    checks++;
    if ({mdu_start, mdu_busy, wpcir, starts} !== {3'b101, 32'd1}) $display("FAIL b2b_reissue start/busy/wpcir=%b starts=%0d exp 101 starts=1", {mdu_start, mdu_busy, wpcir}, starts);
    else passes++;
    tick();
    dmdu = 0; #1;
    checks++;
    if ({mdu_start, mdu_busy} !== 2'b01) $display("FAIL b2b_once start/busy=%b exp 01", {mdu_start, mdu_busy});
    else passes++;
    idle_inputs(); do_reset();
  endtask

  task automatic test_reset_busy_and_sat();
    do_reset();
    dmdu = 1; tick();
    dmdu = 0; dhilo = 1; tick();
    rst = 1; #1;
    checks++;
    if ({mdu_start, wpcir} !== 2'b01) $display("FAIL rst_busy_comb start/wpcir=%b exp 01", {mdu_start, wpcir});
    else passes++;
    tick();
    rst = 0; dhilo = 0; #1;
    checks++;
    if ({mdu_busy, mdu_start, stall_cnt} !== {2'b00, 4'd0}) $display("FAIL rst_busy_after busy/start/cnt=%b exp 00_0000", {mdu_busy, mdu_start, stall_cnt});
    else passes++;
    ewreg = 1; em2reg = 1; ern = 5'd4; rs = 5'd4; use_rs = 1;
    for (int i = 0; i < CMAX - 1; i++) tick();
    checks++;
    if (stall_cnt !== 4'(CMAX - 1)) $display("FAIL sat_pre got %0d exp %0d", stall_cnt, CMAX - 1);
    else passes++;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (stall_cnt !== 4'(CMAX)) $display("FAIL sat_hold got %0d exp %0d", stall_cnt, CMAX);
    else passes++;
    idle_inputs(); #1;
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 99) == 0);
      rs     = 5'($urandom_range(0, 3));
      rt     = 5'($urandom_range(0, 3));
      ern    = 5'($urandom_range(0, 3));
      mrn    = 5'($urandom_range(0, 3));
      use_rs = 1'($urandom); use_rt = 1'($urandom);
      ewreg  = 1'($urandom); em2reg = 1'($urandom);
      mwreg  = 1'($urandom); mm2reg = 1'($urandom);
      dmdu   = ($urandom_range(0, 7) == 0);
      dhilo  = ($urandom_range(0, 3) == 0);
      #1;
      model_eval();
      checks++;
      if ({fwda, fwdb, wpcir, bubble, mdu_start, mdu_busy, stall_cnt} !==
          {m_fwda, m_fwdb, !m_stall, m_stall, m_start, m_busy, 4'(m_cnt)}) begin
        if (errs < 10) $display("FAIL rand_cyc%0d got %h exp %h", n,
          {fwda, fwdb, wpcir, bubble, mdu_start, mdu_busy, stall_cnt},
          {m_fwda, m_fwdb, !m_stall, m_stall, m_start, m_busy, 4'(m_cnt)});
        errs++;
      end else passes++;
      tick();
    end
    rst = 0; idle_inputs(); #1;
  endtask

  initial begin
    rst = 1; idle_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mdu_hilo();
    test_back_to_back();
    test_reset_busy_and_sat();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
